// File: rtl/q_table_pkg.sv
// Shared constants, cell codes and base-3 helpers for the tic-tac-toe Q-table.
package q_table_pkg;

    localparam int unsigned Q_WIDTH     = 16;
    localparam int unsigned STATE_WIDTH = 18;
    localparam int unsigned ADDR_WIDTH  = 15;
    localparam int unsigned DEPTH       = 19683;
    localparam int unsigned N_CELLS     = 9;

    localparam logic [1:0] CELL_EMPTY   = 2'b00;
    localparam logic [1:0] CELL_AGENT   = 2'b01;
    localparam logic [1:0] CELL_USER    = 2'b10;
    localparam logic [1:0] CELL_ILLEGAL = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] POW3 [0:8] = '{
        15'd1, 15'd3, 15'd9, 15'd27, 15'd81, 15'd243, 15'd729, 15'd2187, 15'd6561
    };

    typedef enum logic {INIT, RUN} q_state_t;

    // Weighted base-3 sum of cells lo..hi; the caller discards it when a cell is illegal.
    function automatic logic [ADDR_WIDTH-1:0] weighted_sum(
        input logic [STATE_WIDTH-1:0] s,
        input int unsigned            lo,
        input int unsigned            hi
    );
        logic [ADDR_WIDTH-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < N_CELLS; i++) begin
            if (i >= lo && i <= hi) begin
                acc = acc + ADDR_WIDTH'(s[2*i +: 2]) * POW3[i];
            end
        end
        return acc;
    endfunction

    function automatic logic has_illegal(input logic [STATE_WIDTH-1:0] s);
        logic ill;
        ill = 1'b0;
        for (int unsigned i = 0; i < N_CELLS; i++) begin
            if (s[2*i +: 2] == CELL_ILLEGAL) begin
                ill = 1'b1;
            end
        end
        return ill;
    endfunction

endpackage

// File: rtl/q_table_mem_state_to_index.sv
// Two-stage conversion of an 18-bit board encoding into a dense base-3 bank address.
module state_to_index
    import q_table_pkg::*;
(
    input  logic                   clock,
    input  logic                   rst,
    input  logic [STATE_WIDTH-1:0] state,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic                   illegal
);

    logic [ADDR_WIDTH-1:0] sum_lo_q;
    logic [ADDR_WIDTH-1:0] sum_hi_q;
    logic                  ill_q;

    always_ff @(posedge clock) begin
        if (!rst) begin
            sum_lo_q <= '0;
            sum_hi_q <= '0;
            ill_q    <= 1'b0;
            addr     <= '0;
            illegal  <= 1'b0;
        end else begin
            sum_lo_q <= weighted_sum(state, 0, 4);
            sum_hi_q <= weighted_sum(state, 5, 8);
            ill_q    <= has_illegal(state);
            addr     <= sum_lo_q + sum_hi_q;
            illegal  <= ill_q;
        end
    end

endmodule

// File: rtl/q_table_mem.sv
// Nine-bank Q-value store indexed by board state: pipelined read/write, clear sweep after reset.
module q_table_mem #(
    parameter int unsigned        Q_WIDTH     = 16,
    parameter int unsigned        STATE_WIDTH = 18,
    parameter int unsigned        ADDR_WIDTH  = 15,
    parameter int unsigned        DEPTH       = 19683,
    parameter logic [Q_WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic [STATE_WIDTH-1:0] rd_state,
    input  logic [STATE_WIDTH-1:0] wr_state,
    input  logic [Q_WIDTH-1:0]     wr_data,
    input  logic                   en_ram1,
    input  logic                   en_ram2,
    input  logic                   en_ram3,
    input  logic                   en_ram4,
    input  logic                   en_ram5,
    input  logic                   en_ram6,
    input  logic                   en_ram7,
    input  logic                   en_ram8,
    input  logic                   en_ram9,
    output logic [Q_WIDTH-1:0]     Q_value_act1,
    output logic [Q_WIDTH-1:0]     Q_value_act2,
    output logic [Q_WIDTH-1:0]     Q_value_act3,
    output logic [Q_WIDTH-1:0]     Q_value_act4,
    output logic [Q_WIDTH-1:0]     Q_value_act5,
    output logic [Q_WIDTH-1:0]     Q_value_act6,
    output logic [Q_WIDTH-1:0]     Q_value_act7,
    output logic [Q_WIDTH-1:0]     Q_value_act8,
    output logic [Q_WIDTH-1:0]     Q_value_act9,
    output logic                   init_done,
    output logic                   rd_illegal,
    output logic                   wr_illegal
);
    import q_table_pkg::*;

    q_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  init_we;

    logic [8:0]            wr_en_in;
    logic [8:0]            wr_en_s1, wr_en_s2;
    logic [Q_WIDTH-1:0]    wr_data_s1, wr_data_s2;
    logic                  rd_run_s1, rd_run_s2, rd_run_s3, rd_ill_s3;

    logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
    logic                  rd_ill, wr_ill;

    logic [8:0]            ram_we;
    logic [8:0]            rd_hit;
    logic [ADDR_WIDTH-1:0] ram_waddr, rd_raddr;
    logic [Q_WIDTH-1:0]    ram_wdata;
    logic [Q_WIDTH-1:0]    q_vec [9];

    assign wr_en_in  = {en_ram9, en_ram8, en_ram7, en_ram6, en_ram5,
                        en_ram4, en_ram3, en_ram2, en_ram1};
    assign init_done = (state_q == RUN);

    state_to_index u_rd_idx (
        .clock   (clock),
        .rst     (rst),
        .state   (rd_state),
        .addr    (rd_addr),
        .illegal (rd_ill)
    );

    state_to_index u_wr_idx (
        .clock   (clock),
        .rst     (rst),
        .state   (wr_state),
        .addr    (wr_addr),
        .illegal (wr_ill)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        init_we    = 1'b0;
        case (state_q)
            INIT: begin
                init_we = 1'b1;
                if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Enables are zeroed at sample time during INIT, so discarded writes never flag.
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            wr_en_s1   <= '0;
            wr_en_s2   <= '0;
            rd_run_s1  <= 1'b0;
            rd_run_s2  <= 1'b0;
            rd_run_s3  <= 1'b0;
            rd_ill_s3  <= 1'b0;
            rd_illegal <= 1'b0;
            wr_illegal <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wr_en_s1   <= (state_q == RUN) ? wr_en_in : '0;
            wr_en_s2   <= wr_en_s1;
            rd_run_s1  <= (state_q == RUN);
            rd_run_s2  <= rd_run_s1;
            rd_run_s3  <= rd_run_s2;
            rd_ill_s3  <= rd_ill;
            rd_illegal <= rd_run_s3 && rd_ill_s3;
            wr_illegal <= wr_ill && (wr_en_s2 != '0);
        end
    end

    always_ff @(posedge clock) begin
        wr_data_s1 <= wr_data;
        wr_data_s2 <= wr_data_s1;
    end

    always_comb begin
        ram_waddr = init_we ? init_cnt_q : wr_addr;
        ram_wdata = init_we ? INIT_VALUE : wr_data_s2;
        rd_raddr  = rd_ill ? '0 : rd_addr;
        for (int unsigned k = 0; k < N_CELLS; k++) begin
            ram_we[k] = init_we || (wr_en_s2[k] && !wr_ill);
            rd_hit[k] = wr_en_s2[k] && !wr_ill && !rd_ill && (wr_addr == rd_addr);
        end
    end

    // Write-first on same-address collision keeps reads coherent with same-edge writes.
    for (genvar b = 0; b < N_CELLS; b++) begin : g_bank
        logic [Q_WIDTH-1:0] mem [DEPTH];
        logic [Q_WIDTH-1:0] rd_q;
        logic [Q_WIDTH-1:0] out_q;

        always_ff @(posedge clock) begin
            if (ram_we[b]) begin
                mem[ram_waddr] <= ram_wdata;
            end
            rd_q <= rd_hit[b] ? wr_data_s2 : mem[rd_raddr];
        end

        always_ff @(posedge clock) begin
            if (!rst) begin
                out_q <= '0;
            end else begin
                out_q <= (rd_run_s3 && !rd_ill_s3) ? rd_q : '0;
            end
        end

        assign q_vec[b] = out_q;
    end

    assign Q_value_act1 = q_vec[0];
    assign Q_value_act2 = q_vec[1];
    assign Q_value_act3 = q_vec[2];
    assign Q_value_act4 = q_vec[3];
    assign Q_value_act5 = q_vec[4];
    assign Q_value_act6 = q_vec[5];
    assign Q_value_act7 = q_vec[6];
    assign Q_value_act8 = q_vec[7];
    assign Q_value_act9 = q_vec[8];

endmodule

// File: tb/tb_q_table_mem.sv
// Scoreboard bench for q_table_mem: base-3 reference model, latency-tagged expectation queues.
module tb_q_table_mem;

    logic        clock;
    logic        rst;
    logic [17:0] rd_state, wr_state;
    logic [15:0] wr_data;
    logic        en_ram1, en_ram2, en_ram3, en_ram4, en_ram5, en_ram6, en_ram7, en_ram8, en_ram9;
    logic [15:0] Q_value_act1, Q_value_act2, Q_value_act3, Q_value_act4, Q_value_act5;
    logic [15:0] Q_value_act6, Q_value_act7, Q_value_act8, Q_value_act9;
    logic        init_done, rd_illegal, wr_illegal;
    logic [8:0][15:0] q_obs;

    q_table_mem #(
        .Q_WIDTH     (16),
        .STATE_WIDTH (18),
        .ADDR_WIDTH  (15),
        .DEPTH       (19683),
        .INIT_VALUE  (16'h0000)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .rd_state     (rd_state),
        .wr_state     (wr_state),
        .wr_data      (wr_data),
        .en_ram1      (en_ram1),
        .en_ram2      (en_ram2),
        .en_ram3      (en_ram3),
        .en_ram4      (en_ram4),
        .en_ram5      (en_ram5),
        .en_ram6      (en_ram6),
        .en_ram7      (en_ram7),
        .en_ram8      (en_ram8),
        .en_ram9      (en_ram9),
        .Q_value_act1 (Q_value_act1),
        .Q_value_act2 (Q_value_act2),
        .Q_value_act3 (Q_value_act3),
        .Q_value_act4 (Q_value_act4),
        .Q_value_act5 (Q_value_act5),
        .Q_value_act6 (Q_value_act6),
        .Q_value_act7 (Q_value_act7),
        .Q_value_act8 (Q_value_act8),
        .Q_value_act9 (Q_value_act9),
        .init_done    (init_done),
        .rd_illegal   (rd_illegal),
        .wr_illegal   (wr_illegal)
    );

    assign q_obs = {Q_value_act9, Q_value_act8, Q_value_act7, Q_value_act6, Q_value_act5,
                    Q_value_act4, Q_value_act3, Q_value_act2, Q_value_act1};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int unsigned      due;
        logic [8:0][15:0] q;
        logic             ill;
    } rd_exp_t;

    typedef struct {
        int unsigned due;
        logic        ill;
    } wr_exp_t;

    typedef struct packed {
        logic [17:0] rs;
        logic [17:0] ws;
        logic [15:0] wd;
        logic [8:0]  we;
    } op_t;

    rd_exp_t     rd_sb[$];
    wr_exp_t     wr_sb[$];
    logic [15:0] model_mem [9][19683];
    int unsigned cyc;
    int unsigned compared;
    int unsigned mismatched;

    function automatic int unsigned ref_addr(input logic [17:0] s);
        int unsigned a;
        a = 0;
        for (int i = 8; i >= 0; i--) a = a * 3 + int'(s[2*i +: 2]);
        return a;
    endfunction

    function automatic logic ref_ill(input logic [17:0] s);
        for (int i = 0; i < 9; i++) if (s[2*i +: 2] == 2'b11) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 9; k++)
            for (int a = 0; a < 19683; a++) model_mem[k][a] = 16'h0000;
        rd_sb.delete();
        wr_sb.delete();
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic set_idle();
        rd_state = '0; wr_state = '0; wr_data = '0;
        {en_ram9, en_ram8, en_ram7, en_ram6, en_ram5, en_ram4, en_ram3, en_ram2, en_ram1} = '0;
    endtask

    // Inputs take effect at the next edge; model writes land before the same-edge read.
    task automatic drive(input logic [17:0] rs, input logic [17:0] ws,
                         input logic [15:0] wd, input logic [8:0] we);
        rd_exp_t     re;
        wr_exp_t     wx;
        int unsigned a;
        rd_state = rs; wr_state = ws; wr_data = wd;
        {en_ram9, en_ram8, en_ram7, en_ram6, en_ram5, en_ram4, en_ram3, en_ram2, en_ram1} = we;
        if (!ref_ill(ws)) begin
            a = ref_addr(ws);
            for (int k = 0; k < 9; k++) if (we[k]) model_mem[k][a] = wd;
        end
        wx.due = cyc + 3;
        wx.ill = ref_ill(ws) && (we != 9'h000);
        wr_sb.push_back(wx);
        re.due = cyc + 4;
        re.ill = ref_ill(rs);
        re.q   = '0;
        if (!re.ill) begin
            a = ref_addr(rs);
            for (int k = 0; k < 9; k++) re.q[k] = model_mem[k][a];
        end
        rd_sb.push_back(re);
    endtask

    task automatic wait_init(output int unsigned n);
        set_idle();
        n = 0;
        while (init_done !== 1'b1 && n < 25000) begin
            advance();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rd_state = 18'h2AAAA; wr_state = 18'h00001; wr_data = 16'hFFFF;
        {en_ram9, en_ram8, en_ram7, en_ram6, en_ram5, en_ram4, en_ram3, en_ram2, en_ram1} = 9'h1FF;
        repeat (4) advance();
        compared++;
        if (q_obs !== '0) begin
            mismatched++; $display("FAIL reset_q: got %h want 0", q_obs);
        end
        compared++;
        if ({init_done, rd_illegal, wr_illegal} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_flags: got done/rill/will=%b want 000", {init_done, rd_illegal, wr_illegal});
        end
        set_idle();
    endtask

    task automatic test_init_sweep();
        int unsigned n;
        model_clear();
        rst = 1'b1;
        n = 0;
        while (init_done !== 1'b1 && n < 25000) begin
            advance();
            n++;
            case (n)
                100: begin wr_state = 18'h00009; wr_data = 16'h5555;
                           {en_ram9, en_ram8, en_ram7, en_ram6, en_ram5, en_ram4, en_ram3, en_ram2, en_ram1} = 9'h1FF; end
                101: set_idle();
                200: rd_state = 18'h00003;
                201: rd_state = 18'h00000;
                300: begin wr_state = 18'h00003; wr_data = 16'hDEAD; en_ram1 = 1'b1; end
                301: set_idle();
                default: ;
            endcase
            if (init_done !== 1'b1) begin
                compared++;
                if (q_obs !== '0 || rd_illegal !== 1'b0 || wr_illegal !== 1'b0) begin
                    mismatched++;
                    $display("FAIL init_quiet n=%0d: got q=%h rill=%b will=%b want all 0", n, q_obs, rd_illegal, wr_illegal);
                end
            end
        end
        compared++;
        if (n !== 19683) begin
            mismatched++; $display("FAIL init_len: got %0d cycles want 19683", n);
        end
    endtask

    task automatic test_after_init();
        op_t ops [3];
        ops = '{'{18'h2AAAA, 18'h0, 16'h0, 9'h0},
                '{18'h00009, 18'h0, 16'h0, 9'h0},
                '{18'h00000, 18'h0, 16'h0, 9'h0}};
        for (int i = 0; i < 3 + 5; i++) begin
            if (i < 3) drive(ops[i].rs, ops[i].ws, ops[i].wd, ops[i].we);
            else drive(18'h0, 18'h0, 16'h0, 9'h0);
            advance();
            while (rd_sb.size() != 0 && rd_sb[0].due <= cyc) begin
                rd_exp_t re = rd_sb.pop_front();
                compared++;
                if (q_obs !== re.q || rd_illegal !== re.ill) begin
                    mismatched++;
                    $display("FAIL after_init_rd cyc=%0d: got q=%h ill=%b want q=%h ill=%b", cyc, q_obs, rd_illegal, re.q, re.ill);
                end
            end
            while (wr_sb.size() != 0 && wr_sb[0].due <= cyc) begin
                wr_exp_t wx = wr_sb.pop_front();
                compared++;
                if (wr_illegal !== wx.ill) begin
                    mismatched++; $display("FAIL after_init_wrill cyc=%0d: got %b want %b", cyc, wr_illegal, wx.ill);
                end
            end
        end
    endtask

    task automatic test_write_read();
        op_t ops [4];
        ops = '{'{18'h00000, 18'h00001, 16'h1234, 9'b000010000},
                '{18'h00001, 18'h0, 16'h0, 9'h0},
                '{18'h2AAAA, 18'h0, 16'h0, 9'h0},
                '{18'h00001, 18'h0, 16'h0, 9'h0}};
        for (int i = 0; i < 4 + 5; i++) begin
            if (i < 4) drive(ops[i].rs, ops[i].ws, ops[i].wd, ops[i].we);
            else drive(18'h0, 18'h0, 16'h0, 9'h0);
            advance();
            while (rd_sb.size() != 0 && rd_sb[0].due <= cyc) begin
                rd_exp_t re = rd_sb.pop_front();
                compared++;
                if (q_obs !== re.q || rd_illegal !== re.ill) begin
                    mismatched++;
                    $display("FAIL write_read_rd cyc=%0d: got q=%h ill=%b want q=%h ill=%b", cyc, q_obs, rd_illegal, re.q, re.ill);
                end
            end
            while (wr_sb.size() != 0 && wr_sb[0].due <= cyc) begin
                wr_exp_t wx = wr_sb.pop_front();
                compared++;
                if (wr_illegal !== wx.ill) begin
                    mismatched++; $display("FAIL write_read_wrill cyc=%0d: got %b want %b", cyc, wr_illegal, wx.ill);
                end
            end
        end
    endtask

    task automatic test_forwarding();
        op_t ops [5];
        ops = '{'{18'h20000, 18'h0, 16'h0, 9'h0},
                '{18'h20000, 18'h20000, 16'h00FF, 9'h001},
                '{18'h20000, 18'h20000, 16'h0A0A, 9'h002},
                '{18'h20000, 18'h00001, 16'h5555, 9'h001},
                '{18'h20000, 18'h0, 16'h0, 9'h0}};
        for (int i = 0; i < 5 + 5; i++) begin
            if (i < 5) drive(ops[i].rs, ops[i].ws, ops[i].wd, ops[i].we);
            else drive(18'h00001, 18'h0, 16'h0, 9'h0);
            advance();
            while (rd_sb.size() != 0 && rd_sb[0].due <= cyc) begin
                rd_exp_t re = rd_sb.pop_front();
                compared++;
                if (q_obs !== re.q || rd_illegal !== re.ill) begin
                    mismatched++;
                    $display("FAIL forward_rd cyc=%0d: got q=%h ill=%b want q=%h ill=%b", cyc, q_obs, rd_illegal, re.q, re.ill);
                end
            end
            while (wr_sb.size() != 0 && wr_sb[0].due <= cyc) begin
                wr_exp_t wx = wr_sb.pop_front();
                compared++;
                if (wr_illegal !== wx.ill) begin
                    mismatched++; $display("FAIL forward_wrill cyc=%0d: got %b want %b", cyc, wr_illegal, wx.ill);
                end
            end
        end
    endtask

    task automatic test_illegal();
        op_t ops [5];
        ops = '{'{18'h00003, 18'h00003, 16'hDEAD, 9'h1FF},
                '{18'h30000, 18'h0, 16'h0, 9'h0},
                '{18'h00000, 18'h30000, 16'hDEAD, 9'h1FF},
                '{18'h00000, 18'h0, 16'h0, 9'h0},
                '{18'h00003, 18'h0, 16'h0, 9'h0}};
        for (int i = 0; i < 5 + 5; i++) begin
            if (i < 5) drive(ops[i].rs, ops[i].ws, ops[i].wd, ops[i].we);
            else drive(18'h0, 18'h0, 16'h0, 9'h0);
            advance();
            while (rd_sb.size() != 0 && rd_sb[0].due <= cyc) begin
                rd_exp_t re = rd_sb.pop_front();
                compared++;
                if (q_obs !== re.q || rd_illegal !== re.ill) begin
                    mismatched++;
                    $display("FAIL illegal_rd cyc=%0d: got q=%h ill=%b want q=%h ill=%b", cyc, q_obs, rd_illegal, re.q, re.ill);
                end
            end
            while (wr_sb.size() != 0 && wr_sb[0].due <= cyc) begin
                wr_exp_t wx = wr_sb.pop_front();
                compared++;
                if (wr_illegal !== wx.ill) begin
                    mismatched++; $display("FAIL illegal_wrill cyc=%0d: got %b want %b", cyc, wr_illegal, wx.ill);
                end
            end
        end
    endtask

    task automatic test_multi_enable();
        op_t ops [4];
        ops = '{'{18'h00000, 18'h00004, 16'hBEEF, 9'b100000011},
                '{18'h00004, 18'h0, 16'h0, 9'h0},
                '{18'h00004, 18'h00004, 16'h7777, 9'h000},
                '{18'h00004, 18'h0, 16'h0, 9'h0}};
        for (int i = 0; i < 4 + 5; i++) begin
            if (i < 4) drive(ops[i].rs, ops[i].ws, ops[i].wd, ops[i].we);
            else drive(18'h00004, 18'h0, 16'h0, 9'h0);
            advance();
            while (rd_sb.size() != 0 && rd_sb[0].due <= cyc) begin
                rd_exp_t re = rd_sb.pop_front();
                compared++;
                if (q_obs !== re.q || rd_illegal !== re.ill) begin
                    mismatched++;
                    $display("FAIL multi_en_rd cyc=%0d: got q=%h ill=%b want q=%h ill=%b", cyc, q_obs, rd_illegal, re.q, re.ill);
                end
            end
            while (wr_sb.size() != 0 && wr_sb[0].due <= cyc) begin
                wr_exp_t wx = wr_sb.pop_front();
                compared++;
                if (wr_illegal !== wx.ill) begin
                    mismatched++; $display("FAIL multi_en_wrill cyc=%0d: got %b want %b", cyc, wr_illegal, wx.ill);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] pool [8];
        logic [17:0] rs, ws;
        logic [8:0]  we;
        pool = '{18'h00000, 18'h00001, 18'h00004, 18'h20000,
                 18'h2AAAA, 18'h00003, 18'h15555, 18'h00010};
        for (int i = 0; i < 60 + 5; i++) begin
            if (i < 60) begin
                rs = pool[$urandom_range(0, 7)];
                ws = pool[$urandom_range(0, 7)];
                we = ($urandom_range(0, 3) == 0) ? 9'h000 : 9'($urandom_range(1, 511));
                if (ref_ill(ws) && we == 9'h000) we = 9'h001;
                drive(rs, ws, 16'($urandom), we);
            end else begin
                drive(pool[i % 8], 18'h0, 16'h0, 9'h0);
            end
            advance();
            while (rd_sb.size() != 0 && rd_sb[0].due <= cyc) begin
                rd_exp_t re = rd_sb.pop_front();
                compared++;
                if (q_obs !== re.q || rd_illegal !== re.ill) begin
                    mismatched++;
                    $display("FAIL b2b_rd cyc=%0d: got q=%h ill=%b want q=%h ill=%b", cyc, q_obs, rd_illegal, re.q, re.ill);
                end
            end
            while (wr_sb.size() != 0 && wr_sb[0].due <= cyc) begin
                wr_exp_t wx = wr_sb.pop_front();
                compared++;
                if (wr_illegal !== wx.ill) begin
                    mismatched++; $display("FAIL b2b_wrill cyc=%0d: got %b want %b", cyc, wr_illegal, wx.ill);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        int unsigned n;
        // Park a value at addr 9 and an in-flight write that the reset must cancel.
        drive(18'h00010, 18'h00010, 16'h1111, 9'h1FF);
        repeat (4) advance();
        set_idle();
        rd_state = 18'h00010;
        wr_state = 18'h00010; wr_data = 16'hAAAA;
        {en_ram9, en_ram8, en_ram7, en_ram6, en_ram5, en_ram4, en_ram3, en_ram2, en_ram1} = 9'h1FF;
        advance();
        set_idle();
        rd_state = 18'h00010;
        rst = 1'b0;
        advance();
        compared++;
        if (q_obs !== '0 || init_done !== 1'b0 || rd_illegal !== 1'b0 || wr_illegal !== 1'b0) begin
            mismatched++;
            $display("FAIL midrun_reset_out: got q=%h done=%b rill=%b will=%b want all 0", q_obs, init_done, rd_illegal, wr_illegal);
        end
        advance();
        model_clear();
        rst = 1'b1;
        wait_init(n);
        compared++;
        if (n !== 19683) begin
            mismatched++; $display("FAIL midrun_init_len: got %0d cycles want 19683", n);
        end
        for (int i = 0; i < 2 + 5; i++) begin
            drive(18'h00010, 18'h0, 16'h0, 9'h0);
            advance();
            while (rd_sb.size() != 0 && rd_sb[0].due <= cyc) begin
                rd_exp_t re = rd_sb.pop_front();
                compared++;
                if (q_obs !== re.q || rd_illegal !== re.ill) begin
                    mismatched++;
                    $display("FAIL midrun_after_rd cyc=%0d: got q=%h ill=%b want q=%h ill=%b", cyc, q_obs, rd_illegal, re.q, re.ill);
                end
            end
            while (wr_sb.size() != 0 && wr_sb[0].due <= cyc) begin
                wr_exp_t wx = wr_sb.pop_front();
                compared++;
                if (wr_illegal !== wx.ill) begin
                    mismatched++; $display("FAIL midrun_after_wrill cyc=%0d: got %b want %b", cyc, wr_illegal, wx.ill);
                end
            end
        end
    endtask

    task automatic test_reset_midinit();
        int unsigned n;
        set_idle();
        rst = 1'b0;
        advance();
        rst = 1'b1;
        repeat (5000) advance();
        compared++;
        if (init_done !== 1'b0) begin
            mismatched++; $display("FAIL midinit_done: got %b want 0 at count 5000", init_done);
        end
        rst = 1'b0;
        rd_state = 18'h2AAAA;
        advance();
        compared++;
        if (q_obs !== '0 || init_done !== 1'b0 || rd_illegal !== 1'b0) begin
            mismatched++;
            $display("FAIL midinit_reset_out: got q=%h done=%b rill=%b want all 0", q_obs, init_done, rd_illegal);
        end
        model_clear();
        rst = 1'b1;
        wait_init(n);
        compared++;
        if (n !== 19683) begin
            mismatched++; $display("FAIL midinit_init_len: got %0d cycles want 19683", n);
        end
    endtask

    initial begin
        cyc = 0;
        compared = 0;
        mismatched = 0;
        rst = 1'b0;
        set_idle();
        #1;
        test_reset();
        test_init_sweep();
        test_after_init();
        test_write_read();
        test_forwarding();
        test_illegal();
        test_multi_enable();
        test_back_to_back();
        test_reset_midrun();
        test_reset_midinit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
